// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard/event inputs and per-stage enable, flush and redirect strobes of the pipeline sequencer.
interface pipeline_ctrl_if #(parameter int XLEN = 32);
    logic            load_use_stall;
    logic [2:0]      excpt_in;
    logic [XLEN-1:0] excpt_pc;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic            eret;
    logic            icache_miss;
    logic            icache_ready;
    logic            dcache_miss;
    logic            dcache_ready;
    logic            pc_we;
    logic            if_id_we;
    logic            id_ex_we;
    logic            ex_mem_we;
    logic            mem_wb_we;
    logic            if_id_flush;
    logic            id_ex_flush;
    logic            ex_mem_flush;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] epc_q;
    logic [2:0]      cause_q;
    logic            in_trap;
    logic            halted;
    logic [31:0]     stall_cycles;
    modport master (
        input  load_use_stall, excpt_in, excpt_pc, branch_taken, branch_target, eret,
               icache_miss, icache_ready, dcache_miss, dcache_ready,
        output pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
               if_id_flush, id_ex_flush, ex_mem_flush, redirect, redirect_pc,
               epc_q, cause_q, in_trap, halted, stall_cycles
    );
    modport slave (
        output load_use_stall, excpt_in, excpt_pc, branch_taken, branch_target, eret,
               icache_miss, icache_ready, dcache_miss, dcache_ready,
        input  pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
               if_id_flush, id_ex_flush, ex_mem_flush, redirect, redirect_pc,
               epc_q, cause_q, in_trap, halted, stall_cycles
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: merges stalls, misses, branches and exceptions into stage enables/flushes, PC redirects and trap state.
module pipeline_ctrl #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] HANDLER_ADDR = 32'h0000_2000
) (
    input logic             clk,
    input logic             rst_n,
    pipeline_ctrl_if.master bus
);
    localparam logic [2:0] RUN = 3'd0, IMISS = 3'd1, DMISS = 3'd2, TRAP_REDIRECT = 3'd3, HALT = 3'd4;
    logic [2:0]      state, nxt;
    logic [4:0]      we;
    logic [2:0]      fl;
    logic            redir, exc_take, eret_take, miss;
    logic [XLEN-1:0] redir_pc, epc;
    logic [2:0]      cause;
    logic            in_trap;
    logic [31:0]     stall;
    // we = {pc, if_id, id_ex, ex_mem, mem_wb}; fl = {if_id, id_ex, ex_mem}
    always_comb begin
        we = '1;
        fl = '0;
        redir = 1'b0;
        redir_pc = bus.branch_target;
        nxt = state;
        exc_take = 1'b0;
        eret_take = 1'b0;
        miss = (state == IMISS) ? !bus.icache_ready : bus.icache_miss;
        case (state)
            RUN, IMISS: begin
                if (bus.excpt_in != 3'b000) begin
                    exc_take = 1'b1;
                    we[4] = 1'b0;
                    fl = '1;
                    nxt = in_trap ? HALT : TRAP_REDIRECT;
                end else if (bus.dcache_miss) begin
                    we = '0;
                    nxt = DMISS;
                end else if (bus.branch_taken || bus.eret) begin
                    eret_take = !bus.branch_taken;
                    redir = 1'b1;
                    redir_pc = bus.branch_taken ? bus.branch_target : epc;
                    fl = 3'b110;
                    nxt = RUN;
                end else if (bus.load_use_stall) begin
                    we[4:3] = 2'b00;
                    fl = 3'b010;
                    nxt = miss ? IMISS : RUN;
                end else begin
                    we[4] = !miss;
                    fl[2] = miss;
                    nxt = miss ? IMISS : RUN;
                end
            end
            DMISS: begin
                we = {5{bus.dcache_ready}};
                nxt = bus.dcache_ready ? RUN : DMISS;
            end
            TRAP_REDIRECT: begin
                redir = 1'b1;
                redir_pc = HANDLER_ADDR;
                fl = 3'b100;
                nxt = RUN;
            end
            default: we = '0;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            epc <= '0;
            cause <= '0;
            in_trap <= 1'b0;
            stall <= '0;
        end else begin
            state <= nxt;
            if (exc_take) begin
                epc <= bus.excpt_pc;
                cause <= bus.excpt_in;
            end
            if (state == TRAP_REDIRECT) in_trap <= 1'b1;
            else if (eret_take) in_trap <= 1'b0;
            if (!we[4] && state != HALT && stall != '1) stall <= stall + 32'd1;
        end
    end
    assign {bus.pc_we, bus.if_id_we, bus.id_ex_we, bus.ex_mem_we, bus.mem_wb_we} = rst_n ? we : '0;
    assign {bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush} = rst_n ? fl : '0;
    assign bus.redirect = redir;
    assign bus.redirect_pc = redir_pc;
    assign bus.epc_q = epc;
    assign bus.cause_q = cause;
    assign bus.in_trap = in_trap;
    assign bus.halted = (state == HALT);
    assign bus.stall_cycles = stall;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed vectors through the sequencer with hand-computed enables, flushes, redirects and trap state.
module tb_pipeline_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    pipeline_ctrl_if #(.XLEN(32)) bus ();
    pipeline_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    wire [4:0] we = {bus.pc_we, bus.if_id_we, bus.id_ex_we, bus.ex_mem_we, bus.mem_wb_we};
    wire [2:0] fl = {bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush};
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        bus.load_use_stall = 0;
        bus.excpt_in = 3'b000;
        bus.excpt_pc = '0;
        bus.branch_taken = 0;
        bus.branch_target = '0;
        bus.eret = 0;
        bus.icache_miss = 0;
        bus.icache_ready = 0;
        bus.dcache_miss = 0;
        bus.dcache_ready = 0;
    endtask
    initial begin
        idle();
        #1;
        chk("rst_we", 32'(we), 32'h00);
        chk("rst_fl", 32'(fl), 32'h0);
        chk("rst_stall", bus.stall_cycles, 32'd0);
        chk("rst_epc", bus.epc_q, 32'd0);
        #10 rst_n = 1'b1;
        tick();
        chk("run_we", 32'(we), 32'h1F);
        bus.load_use_stall = 1;
        #1;
        chk("lu_we", 32'(we), 32'h07);
        chk("lu_fl", 32'(fl), 32'h2);
        tick();
        bus.load_use_stall = 0;
        #1;
        chk("lu_stall", bus.stall_cycles, 32'd1);
        chk("lu_after_we", 32'(we), 32'h1F);
        bus.icache_miss = 1;
        #1;
        chk("im_we", 32'(we), 32'h0F);
        chk("im_fl", 32'(fl), 32'h4);
        tick();
        bus.icache_miss = 0;
        #1;
        chk("imiss_we", 32'(we), 32'h0F);
        chk("imiss_fl", 32'(fl), 32'h4);
        tick();
        bus.branch_taken = 1;
        bus.branch_target = 32'h100;
        #1;
        chk("br_redirect", 32'(bus.redirect), 32'd1);
        chk("br_pc", bus.redirect_pc, 32'h100);
        chk("br_fl", 32'(fl), 32'h6);
        chk("br_we", 32'(we), 32'h1F);
        tick();
        bus.branch_taken = 0;
        #1;
        chk("br_run_we", 32'(we), 32'h1F);
        chk("br_stall", bus.stall_cycles, 32'd3);
        bus.dcache_miss = 1;
        #1;
        chk("dm_we", 32'(we), 32'h00);
        chk("dm_fl", 32'(fl), 32'h0);
        tick();
        bus.dcache_miss = 0;
        for (int i = 0; i < 3; i++) begin
            bus.branch_taken = (i == 1);
            bus.branch_target = 32'h300;
            #1;
            chk("dmiss_we", 32'(we), 32'h00);
            chk("dmiss_redirect", 32'(bus.redirect), 32'd0);
            tick();
        end
        bus.branch_taken = 0;
        bus.dcache_ready = 1;
        #1;
        chk("dready_we", 32'(we), 32'h1F);
        tick();
        bus.dcache_ready = 0;
        #1;
        chk("dm_run_we", 32'(we), 32'h1F);
        chk("dm_stall", bus.stall_cycles, 32'd7);
        bus.excpt_in = 3'b001;
        bus.excpt_pc = 32'h44;
        #1;
        chk("ex_fl", 32'(fl), 32'h7);
        chk("ex_we", 32'(we), 32'h0F);
        tick();
        idle();
        #1;
        chk("ex_epc", bus.epc_q, 32'h44);
        chk("ex_cause", 32'(bus.cause_q), 32'd1);
        chk("tr_redirect", 32'(bus.redirect), 32'd1);
        chk("tr_pc", bus.redirect_pc, 32'h2000);
        chk("tr_fl", 32'(fl), 32'h4);
        chk("tr_we", 32'(we), 32'h1F);
        tick();
        chk("tr_in_trap", 32'(bus.in_trap), 32'd1);
        bus.eret = 1;
        #1;
        chk("eret_pc", bus.redirect_pc, 32'h44);
        chk("eret_redirect", 32'(bus.redirect), 32'd1);
        chk("eret_fl", 32'(fl), 32'h6);
        tick();
        bus.eret = 0;
        #1;
        chk("eret_in_trap", 32'(bus.in_trap), 32'd0);
        bus.excpt_in = 3'b101;
        bus.excpt_pc = 32'h80;
        bus.dcache_miss = 1;
        bus.load_use_stall = 1;
        #1;
        chk("pri_fl", 32'(fl), 32'h7);
        chk("pri_we", 32'(we), 32'h0F);
        tick();
        idle();
        #1;
        chk("pri_cause", 32'(bus.cause_q), 32'd5);
        chk("pri_epc", bus.epc_q, 32'h80);
        chk("pri_tr_pc", bus.redirect_pc, 32'h2000);
        tick();
        chk("pri_in_trap", 32'(bus.in_trap), 32'd1);
        bus.excpt_in = 3'b010;
        bus.excpt_pc = 32'h2004;
        #1;
        chk("df_fl", 32'(fl), 32'h7);
        tick();
        idle();
        #1;
        chk("df_halted", 32'(bus.halted), 32'd1);
        for (int i = 0; i < 10; i++) begin
            bus.load_use_stall = (i == 3);
            bus.branch_taken = (i == 5);
            #1;
            chk("halt_we", 32'(we), 32'h00);
            tick();
        end
        idle();
        chk("halt_stall", bus.stall_cycles, 32'd10);
        chk("halt_cause", 32'(bus.cause_q), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("rst2_halted", 32'(bus.halted), 32'd0);
        chk("rst2_epc", bus.epc_q, 32'd0);
        chk("rst2_in_trap", 32'(bus.in_trap), 32'd0);
        chk("rst2_stall", bus.stall_cycles, 32'd0);
        #10 rst_n = 1'b1;
        tick();
        chk("rst2_we", 32'(we), 32'h1F);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
